// File: rtl/itch_msg_framer_pkg.sv
// Shared types and constants for the ITCH message framer and its Add Order decoder.
package itch_msg_framer_pkg;

   localparam logic [7:0]  ITCH_ADD_ORDER_TYPE = 8'h41;
   localparam logic [15:0] ITCH_ADD_ORDER_LEN  = 16'd36;

   typedef struct packed {
      logic [15:0] locate;
      logic [15:0] tracking;
      logic [47:0] timestamp;
      logic [63:0] orderRef;
      logic [7:0]  side;
      logic [31:0] shares;
      logic [63:0] stock;
      logic [31:0] price;
   } addOrderType;

   typedef enum logic [1:0] {
      LEN_HI,
      LEN_LO,
      BODY
   } framerStateType;

endpackage

// File: rtl/itch_msg_framer_if.sv
// Framed ITCH message stream: framer drives (master), downstream consumes (slave).
interface itch_msg_framer_if;

   logic [7:0]  msgDataOut;
   logic        msgValidOut;
   logic        msgSomOut;
   logic        msgEomOut;
   logic [7:0]  msgTypeOut;
   logic [15:0] msgLenOut;
   logic [15:0] msgIdxOut;

   modport master (
      output msgDataOut, msgValidOut, msgSomOut, msgEomOut, msgTypeOut, msgLenOut, msgIdxOut
   );

   modport slave (
      input msgDataOut, msgValidOut, msgSomOut, msgEomOut, msgTypeOut, msgLenOut, msgIdxOut
   );

endinterface

// File: rtl/itch_add_order_decoder.sv
// Collects ITCH Add Order body bytes into field registers; publishes them at EOM of a
// full-length Add Order, in step with the framer's registered EOM.
module itch_add_order_decoder
   import itch_msg_framer_pkg::*;
(
   input  logic        clkIn,
   input  logic        rstIn,
   input  logic [7:0]  msgByteIn,
   input  logic        msgValidIn,
   input  logic [15:0] msgIdxIn,
   input  logic [7:0]  msgTypeIn,
   input  logic        msgEomIn,
   input  logic [15:0] msgLenIn,
   output logic        addOrderValidOut,
   output addOrderType addOrderOut
);

   addOrderType workR;
   addOrderType workNext;
   logic        isAddOrder;
   logic        pulse;

   assign isAddOrder = msgValidIn && (msgTypeIn == ITCH_ADD_ORDER_TYPE);
   assign pulse      = isAddOrder && msgEomIn && (msgLenIn == ITCH_ADD_ORDER_LEN);

   // Fields are exactly as wide as their byte spans, so left shifts flush stale content.
   always_comb begin
      workNext = workR;
      if (isAddOrder) begin
         if (msgIdxIn inside {[16'd1:16'd2]}) begin
            workNext.locate = {workR.locate[7:0], msgByteIn};
         end else if (msgIdxIn inside {[16'd3:16'd4]}) begin
            workNext.tracking = {workR.tracking[7:0], msgByteIn};
         end else if (msgIdxIn inside {[16'd5:16'd10]}) begin
            workNext.timestamp = {workR.timestamp[39:0], msgByteIn};
         end else if (msgIdxIn inside {[16'd11:16'd18]}) begin
            workNext.orderRef = {workR.orderRef[55:0], msgByteIn};
         end else if (msgIdxIn == 16'd19) begin
            workNext.side = msgByteIn;
         end else if (msgIdxIn inside {[16'd20:16'd23]}) begin
            workNext.shares = {workR.shares[23:0], msgByteIn};
         end else if (msgIdxIn inside {[16'd24:16'd31]}) begin
            workNext.stock = {workR.stock[55:0], msgByteIn};
         end else if (msgIdxIn inside {[16'd32:16'd35]}) begin
            workNext.price = {workR.price[23:0], msgByteIn};
         end
      end
   end

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         workR            <= '0;
         addOrderValidOut <= 1'b0;
         addOrderOut      <= '0;
      end else begin
         workR            <= workNext;
         addOrderValidOut <= pulse;
         if (pulse) begin
            addOrderOut <= workNext;
         end
      end
   end

endmodule

// File: rtl/itch_msg_framer.sv
// Splits MoldUDP64 message blocks (2-byte length + body) into framed, registered ITCH
// messages and flags truncated frames and zero-length blocks.
module itch_msg_framer
   import itch_msg_framer_pkg::*;
#(
   parameter bit ADD_ORDER_EN = 1'b1
) (
   input  logic                      clkIn,
   input  logic                      rstIn,
   input  logic [7:0]                dataIn,
   input  logic                      dataValidIn,
   input  logic                      eofIn,
   itch_msg_framer_if.master         msgBus,
   output logic                      addOrderValidOut,
   output addOrderType               addOrderOut,
   output logic                      truncErrOut,
   output logic                      zeroLenErrOut
);

   framerStateType stateR, stateNext, stateAfterByte;
   logic [15:0]    lenR, lenNext;
   logic [15:0]    cntR, cntNext;

   logic [7:0]     dataR, dataNext;
   logic           validR, validNext;
   logic           somR, somNext;
   logic           eomR, eomNext;
   logic [7:0]     typeR, typeNext;
   logic [15:0]    lenOutR, lenOutNext;
   logic [15:0]    idxR, idxNext;
   logic           truncR, truncNext;
   logic           zeroR, zeroNext;

   logic           bodyByte;
   logic           isSom;
   logic           isEom;
   logic           zeroLen;

   assign bodyByte = dataValidIn && (stateR == BODY);
   assign isSom    = (cntR == 16'd0);
   assign isEom    = (cntR == lenR - 16'd1);
   assign zeroLen  = dataValidIn && (stateR == LEN_LO) && ({lenR[15:8], dataIn} == 16'd0);

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         stateR <= LEN_HI;
      end else begin
         stateR <= stateNext;
      end
   end

   // The byte is consumed before eofIn is judged, so a frame ending on EOM is clean.
   always_comb begin
      stateAfterByte = stateR;
      if (dataValidIn) begin
         unique case (stateR)
            LEN_HI:  stateAfterByte = LEN_LO;
            LEN_LO:  stateAfterByte = zeroLen ? LEN_HI : BODY;
            BODY:    stateAfterByte = isEom ? LEN_HI : BODY;
            default: stateAfterByte = LEN_HI;
         endcase
      end
      stateNext = eofIn ? LEN_HI : stateAfterByte;
   end

   always_comb begin
      lenNext    = lenR;
      cntNext    = cntR;
      dataNext   = dataR;
      validNext  = bodyByte;
      somNext    = bodyByte && isSom;
      eomNext    = bodyByte && isEom;
      typeNext   = typeR;
      lenOutNext = lenOutR;
      idxNext    = idxR;
      truncNext  = eofIn && (stateAfterByte != LEN_HI);
      zeroNext   = zeroLen;
      if (dataValidIn && stateR == LEN_HI) begin
         lenNext[15:8] = dataIn;
      end
      if (dataValidIn && stateR == LEN_LO) begin
         lenNext[7:0] = dataIn;
         cntNext      = 16'd0;
      end
      if (bodyByte) begin
         dataNext = dataIn;
         idxNext  = cntR;
         if (!isEom) begin
            cntNext = cntR + 16'd1;
         end
         if (isSom) begin
            typeNext   = dataIn;
            lenOutNext = lenR;
         end
      end
   end

   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         lenR    <= '0;
         cntR    <= '0;
         dataR   <= '0;
         validR  <= 1'b0;
         somR    <= 1'b0;
         eomR    <= 1'b0;
         typeR   <= '0;
         lenOutR <= '0;
         idxR    <= '0;
         truncR  <= 1'b0;
         zeroR   <= 1'b0;
      end else begin
         lenR    <= lenNext;
         cntR    <= cntNext;
         dataR   <= dataNext;
         validR  <= validNext;
         somR    <= somNext;
         eomR    <= eomNext;
         typeR   <= typeNext;
         lenOutR <= lenOutNext;
         idxR    <= idxNext;
         truncR  <= truncNext;
         zeroR   <= zeroNext;
      end
   end

   assign msgBus.msgDataOut  = dataR;
   assign msgBus.msgValidOut = validR;
   assign msgBus.msgSomOut   = somR;
   assign msgBus.msgEomOut   = eomR;
   assign msgBus.msgTypeOut  = typeR;
   assign msgBus.msgLenOut   = lenOutR;
   assign msgBus.msgIdxOut   = idxR;
   assign truncErrOut        = truncR;
   assign zeroLenErrOut      = zeroR;

   generate
      if (ADD_ORDER_EN) begin : genAddOrder
         // Decoder registers alongside the framer outputs, so it sees pre-register values.
         itch_add_order_decoder uDecoder (
            .clkIn            (clkIn),
            .rstIn            (rstIn),
            .msgByteIn        (dataIn),
            .msgValidIn       (bodyByte),
            .msgIdxIn         (cntR),
            .msgTypeIn        (typeNext),
            .msgEomIn         (eomNext),
            .msgLenIn         (lenR),
            .addOrderValidOut (addOrderValidOut),
            .addOrderOut      (addOrderOut)
         );
      end else begin : genNoAddOrder
         assign addOrderValidOut = 1'b0;
         assign addOrderOut      = '0;
      end
   endgenerate

endmodule

// File: tb/tb_itch_msg_framer.sv
// Directed bench for itch_msg_framer: framing, Add Order decode, error pulses, async reset.
module tb_itch_msg_framer;
   import itch_msg_framer_pkg::*;

   logic        clkIn = 1'b0;
   logic        rstIn = 1'b1;
   logic [7:0]  dataIn = '0;
   logic        dataValidIn = 1'b0;
   logic        eofIn = 1'b0;
   logic        addOrderValidOut;
   addOrderType addOrderOut;
   logic        truncErrOut;
   logic        zeroLenErrOut;

   itch_msg_framer_if msgBus ();

   itch_msg_framer uDut (
      .clkIn            (clkIn),
      .rstIn            (rstIn),
      .dataIn           (dataIn),
      .dataValidIn      (dataValidIn),
      .eofIn            (eofIn),
      .msgBus           (msgBus),
      .addOrderValidOut (addOrderValidOut),
      .addOrderOut      (addOrderOut),
      .truncErrOut      (truncErrOut),
      .zeroLenErrOut    (zeroLenErrOut)
   );

   always #5 clkIn = ~clkIn;

   int assertCount = 0;
   int failCount   = 0;

   // Captured output stream, sampled on the falling edge.
   logic [7:0]  capData [256];
   logic        capSom  [256];
   logic        capEom  [256];
   logic [15:0] capIdx  [256];
   logic [7:0]  capType [256];
   logic [15:0] capLen  [256];
   int          capCount = 0;
   int          truncCnt = 0;
   int          zeroCnt  = 0;
   int          aoCnt    = 0;
   logic        aoEom    = 1'b0;
   addOrderType aoLast   = '0;

   always @(negedge clkIn) begin
      if (msgBus.msgValidOut && capCount < 256) begin
         capData[capCount] = msgBus.msgDataOut;
         capSom[capCount]  = msgBus.msgSomOut;
         capEom[capCount]  = msgBus.msgEomOut;
         capIdx[capCount]  = msgBus.msgIdxOut;
         capType[capCount] = msgBus.msgTypeOut;
         capLen[capCount]  = msgBus.msgLenOut;
         capCount++;
      end
      if (truncErrOut) truncCnt++;
      if (zeroLenErrOut) zeroCnt++;
      if (addOrderValidOut) begin
         aoCnt++;
         aoEom  = msgBus.msgEomOut;
         aoLast = addOrderOut;
      end
   end

   task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [7:0] b, input logic e);
      dataValidIn = v;
      dataIn      = b;
      eofIn       = e;
      @(posedge clkIn);
      #1;
      dataValidIn = 1'b0;
      eofIn       = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b, input bit gaps);
      if (gaps) repeat ($urandom_range(0, 2)) drive(1'b0, 8'h00, 1'b0);
      drive(1'b1, b, 1'b0);
   endtask

   task automatic flush();
      repeat (3) drive(1'b0, 8'h00, 1'b0);
   endtask

   task automatic checkByte(input string tag, input int i, input logic [7:0] d, input logic som,
                            input logic eom, input logic [15:0] idx);
      checkEq({tag, ".data"}, 64'(capData[i]), 64'(d));
      checkEq({tag, ".som"}, 64'(capSom[i]), 64'(som));
      checkEq({tag, ".eom"}, 64'(capEom[i]), 64'(eom));
      checkEq({tag, ".idx"}, 64'(capIdx[i]), 64'(idx));
   endtask

   logic [7:0] aoBody [36] = '{
      8'h41,
      8'h00, 8'h01,
      8'h00, 8'h02,
      8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
      8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34,
      8'h42,
      8'h00, 8'h00, 8'h00, 8'h64,
      8'h41, 8'h41, 8'h50, 8'h4C, 8'h20, 8'h20, 8'h20, 8'h20,
      8'h00, 8'h16, 8'hE3, 8'h60
   };

   int base;
   int truncBase;
   int zeroBase;
   int aoBase;

   initial begin
      // Reset state
      repeat (2) @(posedge clkIn);
      #1;
      checkEq("rst.valid", 64'(msgBus.msgValidOut), 64'd0);
      checkEq("rst.data", 64'(msgBus.msgDataOut), 64'd0);
      checkEq("rst.len", 64'(msgBus.msgLenOut), 64'd0);
      checkEq("rst.aoValid", 64'(addOrderValidOut), 64'd0);
      checkEq("rst.aoZero", 64'(addOrderOut != '0), 64'd0);
      rstIn = 1'b0;
      flush();

      // Contiguous 3-byte message
      base = capCount; truncBase = truncCnt; zeroBase = zeroCnt;
      sendByte(8'h00, 0); sendByte(8'h03, 0);
      sendByte(8'h53, 0); sendByte(8'h11, 0); sendByte(8'h22, 0);
      flush();
      checkEq("m3.count", 64'(capCount - base), 64'd3);
      checkByte("m3.b0", base, 8'h53, 1'b1, 1'b0, 16'd0);
      checkByte("m3.b1", base + 1, 8'h11, 1'b0, 1'b0, 16'd1);
      checkByte("m3.b2", base + 2, 8'h22, 1'b0, 1'b1, 16'd2);
      checkEq("m3.len", 64'(capLen[base + 2]), 64'd3);
      checkEq("m3.type", 64'(capType[base + 1]), 64'h53);
      checkEq("m3.errs", 64'(truncCnt - truncBase + zeroCnt - zeroBase), 64'd0);

      // Add Order, length 36
      base = capCount; aoBase = aoCnt;
      sendByte(8'h00, 0); sendByte(8'h24, 0);
      for (int i = 0; i < 36; i++) sendByte(aoBody[i], 0);
      flush();
      checkEq("ao.count", 64'(capCount - base), 64'd36);
      checkEq("ao.pulses", 64'(aoCnt - aoBase), 64'd1);
      checkEq("ao.atEom", 64'(aoEom), 64'd1);
      checkEq("ao.locate", 64'(aoLast.locate), 64'h0001);
      checkEq("ao.tracking", 64'(aoLast.tracking), 64'h0002);
      checkEq("ao.timestamp", 64'(aoLast.timestamp), 64'h0000_0102_0304);
      checkEq("ao.orderRef", aoLast.orderRef, 64'h0000_0000_0000_1234);
      checkEq("ao.side", 64'(aoLast.side), 64'h42);
      checkEq("ao.shares", 64'(aoLast.shares), 64'd100);
      checkEq("ao.stock", aoLast.stock, 64'h4141_504C_2020_2020);
      checkEq("ao.price", 64'(aoLast.price), 64'h0016_E360);
      checkEq("ao.eomIdx", 64'(capIdx[base + 35]), 64'd35);

      // Back-to-back lengths 1 and 2 with random gaps
      base = capCount; truncBase = truncCnt; zeroBase = zeroCnt; aoBase = aoCnt;
      sendByte(8'h00, 1); sendByte(8'h01, 1); sendByte(8'hAA, 1);
      sendByte(8'h00, 1); sendByte(8'h02, 1); sendByte(8'hBB, 1); sendByte(8'hCC, 1);
      flush();
      checkEq("b2b.count", 64'(capCount - base), 64'd3);
      checkByte("b2b.m1", base, 8'hAA, 1'b1, 1'b1, 16'd0);
      checkByte("b2b.m2b0", base + 1, 8'hBB, 1'b1, 1'b0, 16'd0);
      checkByte("b2b.m2b1", base + 2, 8'hCC, 1'b0, 1'b1, 16'd1);
      checkEq("b2b.len", 64'(capLen[base + 2]), 64'd2);
      checkEq("b2b.type", 64'(capType[base + 2]), 64'hBB);
      checkEq("b2b.errs", 64'(truncCnt - truncBase + zeroCnt - zeroBase), 64'd0);
      checkEq("b2b.aoHold", 64'(addOrderOut.price), 64'h0016_E360);

      // Truncated frame, then recovery with eofIn on the EOM byte
      base = capCount; truncBase = truncCnt;
      sendByte(8'h00, 0); sendByte(8'h05, 0); sendByte(8'h01, 0); sendByte(8'h02, 0);
      drive(1'b0, 8'h00, 1'b1);
      flush();
      checkEq("tr.pulses", 64'(truncCnt - truncBase), 64'd1);
      checkEq("tr.count", 64'(capCount - base), 64'd2);
      checkEq("tr.noEom", 64'(capEom[base + 1]), 64'd0);
      base = capCount;
      sendByte(8'h00, 0); sendByte(8'h01, 0);
      drive(1'b1, 8'h58, 1'b1);
      flush();
      checkByte("tr.next", base, 8'h58, 1'b1, 1'b1, 16'd0);
      checkEq("tr.nextType", 64'(capType[base]), 64'h58);
      checkEq("tr.eofAtEom", 64'(truncCnt - truncBase), 64'd1);

      // Zero length, then length-1 'A' (no Add Order pulse)
      base = capCount; zeroBase = zeroCnt; aoBase = aoCnt;
      sendByte(8'h00, 0); sendByte(8'h00, 0);
      flush();
      checkEq("zl.pulses", 64'(zeroCnt - zeroBase), 64'd1);
      checkEq("zl.count", 64'(capCount - base), 64'd0);
      sendByte(8'h00, 0); sendByte(8'h01, 0); sendByte(8'h41, 0);
      flush();
      checkByte("zl.next", base, 8'h41, 1'b1, 1'b1, 16'd0);
      checkEq("zl.noAo", 64'(aoCnt - aoBase), 64'd0);

      // Asynchronous reset mid-body
      sendByte(8'h00, 0); sendByte(8'h04, 0); sendByte(8'h11, 0); sendByte(8'h22, 0);
      checkEq("ar.preValid", 64'(msgBus.msgValidOut), 64'd1);
      #2 rstIn = 1'b1;
      #1;
      checkEq("ar.valid", 64'(msgBus.msgValidOut), 64'd0);
      checkEq("ar.data", 64'(msgBus.msgDataOut), 64'd0);
      checkEq("ar.idx", 64'(msgBus.msgIdxOut), 64'd0);
      checkEq("ar.type", 64'(msgBus.msgTypeOut), 64'd0);
      checkEq("ar.len", 64'(msgBus.msgLenOut), 64'd0);
      checkEq("ar.ao", 64'(addOrderOut != '0), 64'd0);
      @(posedge clkIn);
      #1 rstIn = 1'b0;
      base = capCount; truncBase = truncCnt;
      sendByte(8'h00, 0); sendByte(8'h02, 0); sendByte(8'h77, 0); sendByte(8'h88, 0);
      flush();
      checkEq("ar.count", 64'(capCount - base), 64'd2);
      checkByte("ar.b0", base, 8'h77, 1'b1, 1'b0, 16'd0);
      checkByte("ar.b1", base + 1, 8'h88, 1'b0, 1'b1, 16'd1);
      checkEq("ar.len2", 64'(capLen[base + 1]), 64'd2);
      checkEq("ar.noTrunc", 64'(truncCnt - truncBase), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
